cordic_range_reduce: RTL and testbench
======================================

# cordic_range_reduce

Pre-processing stage placed directly upstream of the CORDIC core in the trigonometry accelerator. It takes an IEEE-754 single-precision angle in radians and performs iterative reduction modulo π/2. The output is a signed fixed-point residual θ ∈ [−π/4, π/4] plus a 2-bit quadrant. The CORDIC core then rotates θ and swaps/negates sin/cos according to the quadrant. Inputs that cannot be reduced are rejected with a one-cycle invalid pulse, which the peripheral wrapper feeds into its interrupt logic.

## Interface
- `MAX_EXP`, default 11: largest accepted unbiased exponent; accepted range is |x| < 2^(MAX_EXP+1).
- `FRAC`, default 30: fraction bits of the internal and output fixed-point format.
- `clk`  in  1  project clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `angle_in`  in  32  IEEE-754 single; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `valid` is raised.
- `valid`  out  1  one-cycle pulse; `theta`/`quadrant`/`invalid` are meaningful during it and held afterwards.
- `theta`  out  32  signed Q2.30 residual.
- `quadrant`  out  2  k mod 4, where x = k·π/2 + θ.
- `invalid`  out  1  asserted together with `valid` for NaN, ±Inf, or exponent > MAX_EXP.

## Operation
- Constants:
  - PI_2 = 0x6487ED51 (π/2 in Q·30).
  - PI_4 = PI_2 >> 1 = 0x3243F6A8.
- Unpack `angle_in`:
  - s = bit 31, e = bits 30:23 − 127.
  - m = {1, bits 22:0}.
  - exp field 0 (zero or subnormal) is flushed to magnitude 0.
- Align magnitude into R, a (MAX_EXP+1+FRAC)-bit unsigned value (Q12.30): R = m·2^(e−23+FRAC).
  - Bits below 2^−FRAC are truncated.
  - e < −FRAC−1 gives R = 0.
- States:
  - IDLE: on `start`, either
    - classify as invalid and go to DONE; or
    - load R, set cnt = MAX_EXP, clear k, and go to REDUCE.
  - REDUCE: one step per cycle.
    - If R ≥ PI_2<<cnt: R −= PI_2<<cnt and k[1:0] += (1<<cnt)[1:0]. Only k[1:0] is kept.
    - cnt decrements; after the cnt = 0 step, go to ADJUST.
  - ADJUST:
    - If R > PI_4 (strict): R −= PI_2 (R becomes signed) and k += 1.
    - If s = 1: θ = −R and quadrant = (−k) mod 4. Otherwise θ = R and quadrant = k.
    - Register the outputs, pulse `valid`, go to IDLE.
  - DONE (invalid path): pulse `valid` and `invalid`, with `theta` = 0 and `quadrant` = 0; go to IDLE.
- θ width: after ADJUST, |R| ≤ π/4 fits in Q2.30, so the low 32 bits are taken as a two's-complement value.
- Negative zero gives θ = 0, quadrant = 0.

## Timing
- Reset values:
  - `busy` = 0, `valid` = 0, `invalid` = 0.
  - `theta` = 0, `quadrant` = 0.
  - State = IDLE.
- Valid input: `start` sampled at edge N. REDUCE runs at edges N+1…N+12 and ADJUST at edge N+13. `valid` is high for the single cycle after edge N+13, i.e. 14 cycles of latency. `busy` is high for cycles N+1 through N+13.
- Invalid input: `valid` and `invalid` are high for the single cycle after edge N+1, i.e. 2 cycles of latency.
- `start` while `busy` is ignored, with no queuing. `start` in the same cycle as `valid` is also ignored; the earliest restart is the cycle after `valid`.
- `rst_n` low mid-operation: return to IDLE at that edge with all outputs at reset values. No `valid` is produced for the aborted request.
- Outputs hold their last values between requests.

## Structure
- Shared package `cordic_pkg`:
  - PI_2, PI_4
  - EXP_BIAS (127)
  - FP_EXP_MAX (255)
  - state enum {IDLE, REDUCE, ADJUST, DONE}
- Sub-module `fp_unpack` (combinational):
  - Classifies NaN, Inf, zero, over-range.
  - Produces the aligned magnitude R and the sign.
  - The FSM and datapath stay in the top module.

## Test plan
- 1.0 (0x3F800000) → after 14 cycles: `theta` = 0xDB7812AF, `quadrant` = 1, `invalid` = 0.
- −1.0 (0xBF800000) → `theta` = 0x2487ED51, `quadrant` = 3.
- 10.0 (0x41200000) → `theta` = 0x24D0701A, `quadrant` = 2. Also check the `busy` window and the single-cycle `valid`.
- 0.5, then subnormal 0x00000001, then −0.0:
  - 0.5 → `theta` = 0x20000000, `quadrant` = 0.
  - subnormal → `theta` = 0, `quadrant` = 0.
  - −0.0 → `theta` = 0, `quadrant` = 0.
- NaN 0x7FC00000, +Inf 0x7F800000, and 4096.0 (0x45800000) → each gives `valid` and `invalid` 2 cycles after `start`, with `theta` = 0 and `quadrant` = 0.
- Extra `start` at cycle 5 is ignored. `rst_n` low at cycle 8 aborts the request: no `valid`, outputs cleared. A fresh 1.0 request afterwards produces the correct result.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC front end: fixed-point angle constants,
// IEEE-754 single-precision exponent limits and the range-reduction FSM states.
package cordic_pkg;

    // pi/2 and pi/4 with 30 fraction bits
    localparam logic [31:0] PI_2 = 32'h6487ED51;
    localparam logic [31:0] PI_4 = PI_2 >> 1;

    localparam int unsigned EXP_BIAS   = 127;
    localparam int unsigned FP_EXP_MAX = 255;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        ADJUST,
        DONE
    } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpacker for an IEEE-754 single-precision angle.
// Classifies NaN / Inf / over-range (exponent > MAX_EXP) as invalid. Zero and
// subnormal inputs are flushed to magnitude 0. The magnitude is aligned into an
// unsigned fixed-point value with FRAC fraction bits; bits below 2^-FRAC are
// truncated.
//   i_fp      : IEEE-754 single input
//   o_sign    : sign bit of the input
//   o_invalid : input cannot be range-reduced
//   o_mag     : aligned magnitude, W = MAX_EXP+1+FRAC bits (meaningful when valid)
module fp_unpack
    import cordic_pkg::*;
#(
    parameter int unsigned MAX_EXP = 11,
    parameter int unsigned FRAC    = 30,
    localparam int unsigned W      = MAX_EXP + 1 + FRAC
) (
    input  logic [31:0]  i_fp,
    output logic         o_sign,
    output logic         o_invalid,
    output logic [W-1:0] o_mag
);

    // The mantissa is parked W bits up and shifted right by
    // RSH_BASE - exp_field, which equals m * 2^(e-23+FRAC) for every accepted
    // exponent. Very small exponents shift everything out, giving 0.
    localparam int unsigned RSH_BASE = W + 23 - FRAC + EXP_BIAS;

    logic [7:0]    w_exp;
    logic [22:0]   w_frac;
    logic          w_nan;
    logic          w_inf;
    logic          w_over;
    logic          w_zero;
    logic [W+23:0] w_ext;
    logic [9:0]    w_rsh;

    assign w_exp  = i_fp[30:23];
    assign w_frac = i_fp[22:0];

    assign w_nan  = (w_exp == 8'(FP_EXP_MAX)) && (w_frac != '0);
    assign w_inf  = (w_exp == 8'(FP_EXP_MAX)) && (w_frac == '0);
    assign w_over = (w_exp != 8'(FP_EXP_MAX)) &&
                    ({24'd0, w_exp} > (EXP_BIAS + MAX_EXP));
    assign w_zero = (w_exp == '0);

    assign w_ext  = {1'b1, w_frac, {W{1'b0}}};
    assign w_rsh  = 10'(RSH_BASE) - {2'b00, w_exp};

    assign o_sign    = i_fp[31];
    assign o_invalid = w_nan | w_inf | w_over;
    assign o_mag     = w_zero ? '0 : W'(w_ext >> w_rsh);

endmodule

// File: rtl/cordic_range_reduce.sv
// Range reduction of an IEEE-754 single angle modulo pi/2 ahead of the CORDIC
// core. Produces a signed Q2.30 residual in [-pi/4, pi/4] and the quadrant
// k mod 4 such that x = k*pi/2 + theta. One restoring-subtract step per cycle
// over MAX_EXP+1 cycles, then a final fold into the symmetric range.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, sampled only in IDLE (and not during valid)
//   angle_in   : IEEE-754 single angle in radians
//   busy       : request in progress
//   valid      : one-cycle result strobe
//   theta      : Q2.30 residual (held between requests)
//   quadrant   : k mod 4 (held between requests)
//   invalid    : NaN, Inf or exponent > MAX_EXP (reported with valid)
module cordic_range_reduce
    import cordic_pkg::*;
#(
    parameter int unsigned MAX_EXP = 11,
    parameter int unsigned FRAC    = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] angle_in,
    output logic        busy,
    output logic        valid,
    output logic [31:0] theta,
    output logic [1:0]  quadrant,
    output logic        invalid
);

    localparam int unsigned W  = MAX_EXP + 1 + FRAC;
    localparam int unsigned CW = $clog2(MAX_EXP + 1);

    state_t         r_state;
    logic [W-1:0]   r_mag;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_k;
    logic           r_sign;
    logic           r_busy;
    logic           r_valid;
    logic           r_invalid;
    logic [31:0]    r_theta;
    logic [1:0]     r_quad;

    logic           w_sign;
    logic           w_invalid;
    logic [W-1:0]   w_mag;
    logic [W-1:0]   w_sub;
    logic [1:0]     w_kstep;
    logic           w_gt;
    logic [31:0]    w_res;
    logic [1:0]     w_kadj;
    logic [31:0]    w_theta;
    logic [1:0]     w_quad;

    fp_unpack #(
        .MAX_EXP (MAX_EXP),
        .FRAC    (FRAC)
    ) u_unpack (
        .i_fp      (angle_in),
        .o_sign    (w_sign),
        .o_invalid (w_invalid),
        .o_mag     (w_mag)
    );

    // Step weight pi/2 * 2^cnt; only the low two bits of 2^cnt matter for k.
    assign w_sub   = W'(PI_2) << r_cnt;
    assign w_kstep = (r_cnt == CW'(0)) ? 2'd1 :
                     (r_cnt == CW'(1)) ? 2'd2 : 2'd0;

    // After REDUCE the magnitude is below pi/2, so it fits in 31 bits and the
    // fold to a negative residual can be done in 32-bit two's complement.
    assign w_gt    = r_mag > W'(PI_4);
    assign w_res   = w_gt ? (r_mag[31:0] - PI_2) : r_mag[31:0];
    assign w_kadj  = r_k + {1'b0, w_gt};
    assign w_theta = r_sign ? (32'd0 - w_res) : w_res;
    assign w_quad  = r_sign ? (2'd0 - w_kadj) : w_kadj;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mag     <= '0;
            r_cnt     <= '0;
            r_k       <= '0;
            r_sign    <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_invalid <= 1'b0;
            r_theta   <= '0;
            r_quad    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !r_valid) begin
                        r_busy <= 1'b1;
                        if (w_invalid) begin
                            r_state <= DONE;
                        end else begin
                            r_mag   <= w_mag;
                            r_sign  <= w_sign;
                            r_cnt   <= CW'(MAX_EXP);
                            r_k     <= '0;
                            r_state <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    if (r_mag >= w_sub) begin
                        r_mag <= r_mag - w_sub;
                        r_k   <= r_k + w_kstep;
                    end
                    if (r_cnt == '0) begin
                        r_state <= ADJUST;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ADJUST: begin
                    r_theta   <= w_theta;
                    r_quad    <= w_quad;
                    r_invalid <= 1'b0;
                    r_valid   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                DONE: begin
                    r_theta   <= '0;
                    r_quad    <= '0;
                    r_invalid <= 1'b1;
                    r_valid   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign theta    = r_theta;
    assign quadrant = r_quad;
    assign invalid  = r_invalid;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Directed-vector bench for cordic_range_reduce with hand-computed results.
module tb_cordic_range_reduce;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] angle_in;
    logic        busy;
    logic        valid;
    logic [31:0] theta;
    logic [1:0]  quadrant;
    logic        invalid;

    int n_vec = 0;
    int n_err = 0;

    cordic_range_reduce #(
        .MAX_EXP (11),
        .FRAC    (30)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .angle_in (angle_in),
        .busy     (busy),
        .valid    (valid),
        .theta    (theta),
        .quadrant (quadrant),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to its valid strobe. extra pulses a
    // second start (10.0) at cycles 5..6 that must be ignored. A start is also
    // raised during the valid cycle, which must be ignored too.
    task automatic run(input string tag, input logic [31:0] ang,
                       input logic [31:0] eth, input logic [1:0] eq,
                       input logic einv, input int elat, input bit extra);
        int lat = 0;
        int busy_bad = 0;
        @(negedge clk);
        start    = 1'b1;
        angle_in = ang;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (extra && c == 5) begin
                start    = 1'b1;
                angle_in = 32'h41200000;
            end else if (extra && c == 6) begin
                start = 1'b0;
            end
            if (busy !== (c < elat)) busy_bad++;
            if (valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " busy"}, 32'(busy_bad), 32'd0);
        chk({tag, " theta"}, theta, eth);
        chk({tag, " quadrant"}, {30'd0, quadrant}, {30'd0, eq});
        chk({tag, " invalid"}, {31'd0, invalid}, {31'd0, einv});
        start    = 1'b1;
        angle_in = 32'h3F800000;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " valid 1cyc"}, {31'd0, valid}, 32'd0);
        chk({tag, " start@valid ignored"}, {31'd0, busy}, 32'd0);
        chk({tag, " theta held"}, theta, eth);
        chk({tag, " invalid held"}, {31'd0, invalid}, {31'd0, einv});
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        angle_in = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst valid", {31'd0, valid}, 32'd0);
        chk("rst invalid", {31'd0, invalid}, 32'd0);
        chk("rst theta", theta, 32'd0);
        chk("rst quadrant", {30'd0, quadrant}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("1.0",   32'h3F800000, 32'hDB7812AF, 2'd1, 1'b0, 14, 1'b0);
        run("-1.0",  32'hBF800000, 32'h2487ED51, 2'd3, 1'b0, 14, 1'b0);
        run("10.0",  32'h41200000, 32'h24D0701A, 2'd2, 1'b0, 14, 1'b0);
        run("0.5",   32'h3F000000, 32'h20000000, 2'd0, 1'b0, 14, 1'b0);
        run("subn",  32'h00000001, 32'h00000000, 2'd0, 1'b0, 14, 1'b0);
        run("-0.0",  32'h80000000, 32'h00000000, 2'd0, 1'b0, 14, 1'b0);
        run("NaN",   32'h7FC00000, 32'h00000000, 2'd0, 1'b1, 2,  1'b0);
        run("+Inf",  32'h7F800000, 32'h00000000, 2'd0, 1'b1, 2,  1'b0);
        run("4096",  32'h45800000, 32'h00000000, 2'd0, 1'b1, 2,  1'b0);
        run("1.0x",  32'h3F800000, 32'hDB7812AF, 2'd1, 1'b0, 14, 1'b1);

        // Abort: 1.0 with an ignored start at cycle 5, reset at cycle 8.
        @(negedge clk);
        start    = 1'b1;
        angle_in = 32'h3F800000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 5) begin
                start    = 1'b1;
                angle_in = 32'h41200000;
            end
            if (c == 6) start = 1'b0;
            if (c == 8) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort valid", {31'd0, valid}, 32'd0);
        chk("abort theta", theta, 32'd0);
        chk("abort quadrant", {30'd0, quadrant}, 32'd0);
        chk("abort invalid", {31'd0, invalid}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = 1'b1;
        end
        chk("abort no valid", {31'd0, seen}, 32'd0);

        run("1.0 post", 32'h3F800000, 32'hDB7812AF, 2'd1, 1'b0, 14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
